// File: rtl/diag_collector.sv
// diag_collector: reassembles a 4x4 matrix from a 7-beat skewed
// anti-diagonal stream on four lanes and holds it for a consumer.
//
// Handshakes: a transfer happens on a rising edge where the producer's
// valid and the receiver's ready are both high. in_ready is a function of
// state only; out_valid stays high, with m* stable, until out_ready is seen.
// clear overrides both handshakes on the same edge.
module diag_collector #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] d1,
  input  logic [WIDTH-1:0] d2,
  input  logic [WIDTH-1:0] d3,
  input  logic [WIDTH-1:0] d4,
  input  logic             clear,
  output logic [WIDTH-1:0] m11, m12, m13, m14,
  output logic [WIDTH-1:0] m21, m22, m23, m24,
  output logic [WIDTH-1:0] m31, m32, m33, m34,
  output logic [WIDTH-1:0] m41, m42, m43, m44,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [2:0]       beat,
  output logic             dbg_state
);

  typedef enum logic {
    COLLECT = 1'b0,
    DONE    = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [2:0]       beat_q, beat_d;
  logic [WIDTH-1:0] m_q [4][4];
  logic [WIDTH-1:0] m_d [4][4];
  logic [WIDTH-1:0] lane [4];
  logic             accept;

  assign lane[0] = d1;
  assign lane[1] = d2;
  assign lane[2] = d3;
  assign lane[3] = d4;

  assign in_ready  = (state_q == COLLECT);
  assign out_valid = (state_q == DONE);
  assign beat      = beat_q;
  assign dbg_state = state_q;
  assign accept    = in_valid && in_ready && !clear;

  // Next state and beat counter; clear wins over accept and out_ready.
  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
    if (clear) begin
      state_d = COLLECT;
      beat_d  = 3'd1;
    end else begin
      case (state_q)
        COLLECT: begin
          if (in_valid) begin
            if (beat_q == 3'd7) begin
              beat_d  = 3'd1;
              state_d = DONE;
            end else begin
              beat_d = beat_q + 3'd1;
            end
          end
        end
        DONE: begin
          if (out_ready) state_d = COLLECT;
        end
        default: state_d = COLLECT;
      endcase
    end
  end

  // Element (r,c) (0-based) lives on anti-diagonal r+c+1. Beats 1..4 start
  // the diagonal at row 0, so lane = row; beats 5..7 start it at column 3,
  // so lane counts down from the right edge (3-c).
  always_comb begin
    m_d = m_q;
    if (accept) begin
      for (int r = 0; r < 4; r++) begin
        for (int c = 0; c < 4; c++) begin
          if (r + c + 1 == int'(beat_q)) begin
            m_d[r][c] = (beat_q <= 3'd4) ? lane[r] : lane[3-c];
          end
        end
      end
    end
  end

  // State, beat and matrix registers; reset discards any partial matrix.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= COLLECT;
      beat_q  <= 3'd1;
      for (int r = 0; r < 4; r++) begin
        for (int c = 0; c < 4; c++) begin
          m_q[r][c] <= '0;
        end
      end
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      m_q     <= m_d;
    end
  end

  assign m11 = m_q[0][0];
  assign m12 = m_q[0][1];
  assign m13 = m_q[0][2];
  assign m14 = m_q[0][3];
  assign m21 = m_q[1][0];
  assign m22 = m_q[1][1];
  assign m23 = m_q[1][2];
  assign m24 = m_q[1][3];
  assign m31 = m_q[2][0];
  assign m32 = m_q[2][1];
  assign m33 = m_q[2][2];
  assign m34 = m_q[2][3];
  assign m41 = m_q[3][0];
  assign m42 = m_q[3][1];
  assign m43 = m_q[3][2];
  assign m44 = m_q[3][3];

endmodule

// File: doc/diag_collector.md
# diag_collector

Reassembles a 4x4 matrix of 32-bit words from the skewed anti-diagonal stream that the systolic datapath emits on four lanes over seven beats. It is the receive-side counterpart of the diagonal dispatcher. It sits at the array output, collects beats 1..7 into a row/column-addressed register file, and presents the full matrix to the writeback stage under a valid/ready handshake.

## Interface
- WIDTH, 32, lane and element width (FP32 words, treated as opaque bits)
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- in_valid  input  1  beat present on d1..d4
- in_ready  output  1  collector accepts a beat this cycle
- d1, d2, d3, d4  input  WIDTH each  diagonal lanes; lane i is the i-th element of the current anti-diagonal
- clear  input  1  synchronous abort of the matrix currently being collected
- m11..m14, m21..m24, m31..m34, m41..m44  output  WIDTH each  reassembled matrix, row-major (mRC)
- out_valid  output  1  matrix complete and stable
- out_ready  input  1  consumer takes the matrix
- beat  output  3  index (1..7) of the next beat to be accepted

## Operation
- States:
  - COLLECT: beat runs 1..7.
  - DONE: matrix held for the consumer.
- in_ready = (state == COLLECT). It is combinational from state only.
- A beat is accepted on a rising edge with in_valid && in_ready.
- Lane mapping for accepted beat k, lane i:
  - k = 1..4: lanes 1..k are used. Lane i is written to row i, column k-i+1.
  - k = 5..7: lanes 1..8-k are used. Lane i is written to row k-4+i, column 5-i.
  - Examples: k=4 gives d1→m14, d2→m23, d3→m32, d4→m41. k=5 gives d1→m24, d2→m33, d3→m42. k=7 gives d1→m44.
- Unused lanes are ignored. No matrix element is written at any other time.
- Each element is written exactly once per matrix.
- beat advances by 1 on each accept. When beat 7 is accepted, beat returns to 1 and the state becomes DONE.
- DONE: out_valid = 1. m* are stable and in_valid is ignored.
- out_valid && out_ready ends DONE: next state is COLLECT, out_valid = 0.
- clear (COLLECT or DONE): next state is COLLECT, beat = 1, out_valid = 0, and m* are left unchanged.
  - clear has priority over a simultaneous accept and over a simultaneous out_ready.
- No arithmetic is performed. Data passes bit-exact.

## Timing
- Reset values: state COLLECT, beat = 1, out_valid = 0, all m* = 0.
  - in_ready therefore reads 1 out of reset.
- rst asserted mid-matrix or during DONE: all of the above take effect immediately (asynchronous). Partially collected data is discarded.
- Element latency: an element appears on its m output the cycle after the edge that accepts its beat.
- Matrix latency: out_valid rises the cycle after the edge that accepts beat 7.
  - With in_valid held high, 7 beats give out_valid at cycle 8.
- Handoff: when out_ready is sampled high with out_valid, out_valid drops on that edge. in_ready is high the following cycle.
  - This leaves a 1-cycle bubble, so minimum matrix spacing is 8 cycles.
- out_ready while out_valid = 0 has no effect.
- in_valid low during COLLECT: the collector stalls. beat and m* hold, and gaps of any length are allowed between beats.
- m* of the previous matrix remain visible during the next COLLECT until overwritten. Consumers must qualify them with out_valid.

## Test plan
- Reset, then 7 back-to-back beats of the skew of a matrix with mRC = 32'h0000_00RC (lane values per the mapping, unused lanes driven 32'hDEAD_BEEF) → out_valid at cycle 8, m23 = 32'h23, m41 = 32'h41. No m* equals DEAD_BEEF.
- Same stream with in_valid deasserted for 3 cycles after beats 2 and 5 → identical matrix, out_valid 6 cycles later than the back-to-back case, beat frozen during the gaps.
- Hold out_ready = 0 for 10 cycles in DONE while driving in_valid = 1 with junk → in_ready = 0, m* unchanged, out_valid held. Raise out_ready → out_valid falls, in_ready = 1 next cycle, beat = 1.
- Assert clear together with in_valid at beat 4 → that beat is not written, beat = 1, out_valid stays 0. A following full 7-beat stream yields the new matrix exactly.
- Assert rst asynchronously (mid-cycle) at beat 5 → beat = 1, out_valid = 0, m* = 0 immediately. Resume streaming after release → correct matrix.
- Two matrices back-to-back with out_ready tied high → out_valid pulses one cycle per matrix, spaced 8 cycles apart. Second matrix's m* correct, with no first-matrix value leaking into it.
